wb_master_pipelined: RTL and testbench
======================================

Name: wb_master_pipelined

Overview:
Synthesizable Wishbone B4 pipelined master (initiator) with a 16-bit address and data bus. It accepts burst commands on a simple valid/ready command port and issues incrementing-address pipelined bus cycles, honouring STALL. It counts outstanding transactions and returns one response per ACK. It is the bus-side counterpart of wb_slave_pipelined and replaces the behavioural bench tasks in system-level benches.

Parameters:
adr_width, 16, Wishbone address width
dat_width, 16, Wishbone data width
len_width, 4, burst length field width; a burst carries cmd_len+1 beats (1..2^len_width)
timeout, 255, cycles without an ACK, while transactions are outstanding, before the cycle is aborted; range 1..65535

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted on a cycle with cmd_valid && cmd_ready
cmd_we  in  1  1 = write burst, 0 = read burst
cmd_adr  in  adr_width  start address
cmd_len  in  len_width  beats minus one
wr_valid  in  1  write data available
wr_data  in  dat_width  write data for the next beat
wr_ready  out  1  pulses when the current write beat is accepted by the slave
rsp_valid  out  1  one-cycle pulse per ACKed beat
rsp_data  out  dat_width  read data captured at ACK; holds the last value on writes
done  out  1  one-cycle pulse at the end of the bus cycle
err  out  1  qualifies done: 1 = aborted by timeout
wb_cyc  out  1  Wishbone CYC
wb_stb  out  1  Wishbone STB
wb_we  out  1  Wishbone WE
wb_adr  out  adr_width  Wishbone ADR
wb_dat_m  out  dat_width  master-to-slave data
wb_dat_s  in  dat_width  slave-to-master data
wb_ack  in  1  Wishbone ACK
wb_stall  in  1  Wishbone STALL

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0 except cmd_ready=1; counters cleared. Reset mid-burst drops CYC/STB immediately, with no done pulse.
- States: IDLE, ISSUE, DRAIN.
- IDLE: cmd_ready=1. On accept at edge N, latch we, adr, and beats = cmd_len+1. From cycle N+1: wb_cyc=1, wb_we=cmd_we, wb_adr=cmd_adr; go to ISSUE.
- ISSUE, STB:
  - Reads: wb_stb=1 continuously.
  - Writes: wb_stb = wr_valid, and wb_dat_m = wr_data.
  - A beat is issued at an edge with wb_stb && !wb_stall. For writes, wr_ready = wb_stb && !wb_stall, combinational.
- ISSUE, address and progress:
  - On each issued beat, wb_adr increments by 1, wrapping modulo 2^adr_width.
  - On each issued beat, remaining decrements.
  - When the last beat issues, go to DRAIN; wb_stb=0 from the next cycle.
  - While stalled, ADR, DAT and WE hold stable.
- Outstanding counter (len_width+1 bits): next = cur + issued - acked. Both can change on the same edge. An ACK while the counter is 0 is spurious: ignored, no rsp.
- Response: on each counted ACK edge, rsp_valid=1 in the following cycle; rsp_data = wb_dat_s sampled at that edge when reading. There is no backpressure on rsp.
- DRAIN: when outstanding reaches 0 (including an ACK on the same edge as the last issue), go to IDLE. wb_cyc=0 and done=1 (err=0) in the next cycle. cmd_ready returns in that same cycle. There is no back-to-back CYC merging.
- Timeout:
  - The counter clears on any counted ACK, and on entry to ISSUE.
  - It increments each cycle in ISSUE/DRAIN while outstanding>0.
  - On reaching timeout: wb_cyc=0, wb_stb=0, done=1, err=1 next cycle; go to IDLE; drop any remaining beats.
  - Write-stream underflow (wr_valid=0) with outstanding=0 does not time out.
- Single beat (cmd_len=0): STB is high for exactly one cycle when not stalled.
- Maximum latency, zero-wait slave: an N-beat read completes with CYC high for N+1 cycles.

Test Plan:
- Single write: cmd adr=1, len=0, we=1, wr_data=101, slave waitcycles=0 -> STB is high 1 cycle, one rsp_valid, done with err=0, slave location 1 = 101.
- Read burst: adr=11, len=9, waitcycles=0 -> ADR 11..20 on consecutive cycles, STB high 10 cycles, 10 rsp_valid pulses carrying the previously written 211..220, CYC low after the 10th ACK.
- Stall handling: waitcycles=3, write burst of 4 at adr=0xFFFE -> ADR sequence FFFE, FFFF, 0000, 0001; each held while stalled; exactly 4 wr_ready pulses.
- Write stream gaps: wr_valid toggles 1,0,1,0 during a 4-beat burst -> STB follows wr_valid, 4 beats are issued in order, outstanding never exceeds 4.
- Timeout: slave never ACKs, timeout=8, read len=0 -> done=1 with err=1 exactly 8 cycles after the beat issues; CYC low; cmd_ready=1 next cycle.
- Reset mid-burst: rst_n low during beat 3 of 8 -> CYC, STB and rsp_valid go 0 asynchronously, no done pulse; a fresh command after release runs normally.

Source files
------------

// File: rtl/wb_master_pipelined.sv
// Wishbone B4 pipelined master: turns valid/ready burst commands into incrementing-address
// pipelined bus cycles, honours STALL, tracks outstanding beats and aborts on ACK timeout.
module wb_master_pipelined #(
    parameter int adr_width = 16,
    parameter int dat_width = 16,
    parameter int len_width = 4,
    parameter int timeout   = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    // Command port: a command transfers on a cycle with cmd_valid && cmd_ready.
    // Write data port: a beat's wr_data is consumed on a cycle with wr_valid && wr_ready.
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_we,
    input  logic [adr_width-1:0] cmd_adr,
    input  logic [len_width-1:0] cmd_len,
    input  logic                 wr_valid,
    input  logic [dat_width-1:0] wr_data,
    output logic                 wr_ready,
    output logic                 rsp_valid,
    output logic [dat_width-1:0] rsp_data,
    output logic                 done,
    output logic                 err,
    output logic                 wb_cyc,
    output logic                 wb_stb,
    output logic                 wb_we,
    output logic [adr_width-1:0] wb_adr,
    output logic [dat_width-1:0] wb_dat_m,
    input  logic [dat_width-1:0] wb_dat_s,
    input  logic                 wb_ack,
    input  logic                 wb_stall,
    output logic [1:0]           dbg_state_o
);

    localparam int CW = len_width + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 we_q, we_d;
    logic [adr_width-1:0] adr_q, adr_d;
    logic [CW-1:0]        rem_q, rem_d;
    logic [CW-1:0]        out_q, out_d, out_n;
    logic [15:0]          tmo_q, tmo_d;
    logic                 rsp_valid_q;
    logic [dat_width-1:0] rsp_data_q;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic                 issue, ack_cnt, last_issue, tmo_hit;

    assign cmd_ready   = (state_q == IDLE);
    assign wb_cyc      = (state_q != IDLE);
    assign wb_stb      = (state_q == ISSUE) && (!we_q || wr_valid);
    assign wb_we       = wb_cyc && we_q;
    assign wb_adr      = adr_q;
    assign wb_dat_m    = (state_q == ISSUE && we_q) ? wr_data : '0;
    assign issue       = wb_stb && !wb_stall;
    assign wr_ready    = we_q && issue;
    // An ACK with nothing outstanding is spurious and never counted.
    assign ack_cnt     = wb_ack && (out_q != '0);
    assign out_n       = out_q + CW'(issue) - CW'(ack_cnt);
    assign last_issue  = issue && (rem_q == CW'(1));
    assign tmo_hit     = (out_q != '0) && !ack_cnt && ((17'(tmo_q) + 17'd1) == 17'(timeout));
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign done        = done_q;
    assign err         = err_q;
    assign dbg_state_o = state_q;

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        adr_d   = adr_q;
        rem_d   = rem_q;
        out_d   = out_n;
        tmo_d   = tmo_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                out_d = '0;
                tmo_d = '0;
                if (cmd_valid) begin
                    we_d    = cmd_we;
                    adr_d   = cmd_adr;
                    rem_d   = CW'(cmd_len) + CW'(1);
                    state_d = ISSUE;
                end
            end
            ISSUE, DRAIN: begin
                if (ack_cnt)
                    tmo_d = '0;
                else if (out_q != '0)
                    tmo_d = tmo_q + 16'd1;
                if (issue) begin
                    adr_d = adr_q + adr_width'(1);
                    rem_d = rem_q - CW'(1);
                end
                // Timeout drops any beats not yet issued.
                if (tmo_hit) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    out_d   = '0;
                    rem_d   = '0;
                end else if ((state_q == DRAIN || last_issue) && out_n == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (last_issue) begin
                    state_d = DRAIN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            adr_q       <= '0;
            rem_q       <= '0;
            out_q       <= '0;
            tmo_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            rem_q       <= rem_d;
            out_q       <= out_d;
            tmo_q       <= tmo_d;
            rsp_valid_q <= ack_cnt;
            if (ack_cnt && !we_q)
                rsp_data_q <= wb_dat_s;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_wb_master_pipelined.sv
// Self-checking bench for wb_master_pipelined: a behavioural pipelined slave, a memory
// reference model and a scoreboard of expected responses, beat addresses and done/err.
module tb_wb_master_pipelined;
  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int LW  = 4;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0] cmd_adr;
  logic [LW-1:0] cmd_len;
  logic          wr_valid, wr_ready;
  logic [DW-1:0] wr_data;
  logic          rsp_valid, done, err;
  logic [DW-1:0] rsp_data;
  logic          wb_cyc, wb_stb, wb_we, wb_ack, wb_stall;
  logic [AW-1:0] wb_adr;
  logic [DW-1:0] wb_dat_m, wb_dat_s;
  logic [1:0]    dbg_state;

  wb_master_pipelined #(.adr_width(AW), .dat_width(DW), .len_width(LW), .timeout(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_adr(cmd_adr),
    .cmd_len(cmd_len), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .done(done), .err(err),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
    .wb_dat_m(wb_dat_m), .wb_dat_s(wb_dat_s), .wb_ack(wb_ack), .wb_stall(wb_stall),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] exp_adr_q[$];
  logic          exp_err_q[$];
  logic [DW-1:0] ref_mem[65536];
  logic [DW-1:0] slv_mem[65536];
  logic [DW-1:0] wdata[16];
  logic [DW-1:0] hold_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_msg(input string name, input string what);
    checks++;
    errors++;
    $display("FAIL %s: %s", name, what);
  endtask

  // ---------------- behavioural slave ----------------
  int   waitcycles = 0;
  bit   no_ack = 0;
  bit   spur_req = 0;
  int   wait_cnt = 0;
  bit   pend_ack = 0;
  logic [DW-1:0] pend_dat = '0;
  int   issue_edge = 0;

  initial begin
    wb_ack = 1'b0;
    wb_stall = 1'b0;
    wb_dat_s = '0;
    forever begin
      @(posedge clk);
      #2;
      wb_ack   = pend_ack || spur_req;
      wb_dat_s = pend_dat;
      spur_req = 0;
      pend_ack = 0;
      wb_stall = wb_cyc && wb_stb && (wait_cnt < waitcycles);
      @(negedge clk);
      if (!rst_n) begin
        wait_cnt = 0;
        pend_ack = 0;
      end else if (wb_cyc && wb_stb) begin
        if (wb_stall) begin
          wait_cnt++;
        end else begin
          wait_cnt = 0;
          issue_edge = cyc_n + 1;
          if (exp_adr_q.size() == 0)
            fail_msg("beat_adr", $sformatf("got beat at %0h, expected no beat", wb_adr));
          else
            check("beat_adr", wb_adr, exp_adr_q.pop_front());
          if (wb_we) begin
            slv_mem[wb_adr] = wb_dat_m;
            pend_dat = DW'($urandom);
          end else begin
            pend_dat = slv_mem[wb_adr];
          end
          pend_ack = !no_ack;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  int cyc_hi = 0, stb_hi = 0, wrr_cnt = 0, done_cnt = 0, rsp_cnt = 0, done_edge = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (wb_cyc) cyc_hi++;
      if (wb_stb) stb_hi++;
      if (wr_ready) wrr_cnt++;
      if (rsp_valid) begin
        rsp_cnt++;
        if (exp_q.size() == 0)
          fail_msg("rsp", $sformatf("got rsp_valid with data %0h, expected none", rsp_data));
        else
          check("rsp_data", rsp_data, exp_q.pop_front());
      end
      if (done) begin
        done_cnt++;
        done_edge = cyc_n;
        if (exp_err_q.size() == 0)
          fail_msg("done", "got done pulse, expected none");
        else
          check("done_err", err, exp_err_q.pop_front());
      end
    end
  end

  // ---------------- driver ----------------
  task automatic run_cmd(input bit we, input logic [AW-1:0] adr, input int beats,
                         input int gap, input bit exp_err);
    int idx;
    int k;
    int r0;
    logic [AW-1:0] a;
    for (int i = 0; i < beats; i++) begin
      a = adr + AW'(i);
      exp_adr_q.push_back(a);
      if (!exp_err) begin
        if (we) begin
          ref_mem[a] = wdata[i];
          exp_q.push_back(hold_data);
        end else begin
          exp_q.push_back(ref_mem[a]);
          hold_data = ref_mem[a];
        end
      end
    end
    exp_err_q.push_back(exp_err);
    @(posedge clk);
    #1;
    cyc_hi = 0; stb_hi = 0; wrr_cnt = 0; done_cnt = 0;
    r0 = rsp_cnt;
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_len = LW'(beats - 1);
    k = 0;
    while (!cmd_ready && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (k >= 50) fail_msg("cmd_ready", "got cmd_ready=0 for 50 cycles, expected 1");
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    idx = 0;
    k = 0;
    while (!done && k < 400) begin
      if (we) begin
        case (gap)
          0: wr_valid = (idx < beats);
          1: wr_valid = (idx < beats) && (k % 2 == 0);
          default: wr_valid = (idx < beats) && ($urandom_range(0, 1) == 1);
        endcase
        wr_data = wdata[(idx < beats) ? idx : 0];
      end
      @(negedge clk);
      if (wr_ready) idx++;
      @(posedge clk);
      #1;
      k++;
    end
    wr_valid = 1'b0;
    if (k >= 400) fail_msg("done_wait", "got no done within 400 cycles, expected done");
    check("cyc_at_done", wb_cyc, 1'b0);
    check("cmd_ready_at_done", cmd_ready, 1'b1);
    @(negedge clk);
    #1;
    check("rsp_count", rsp_cnt - r0, exp_err ? 0 : beats);
    if (we && !exp_err) begin
      check("wr_ready_count", wrr_cnt, beats);
      for (int i = 0; i < beats; i++)
        check("slave_mem", slv_mem[adr + AW'(i)], wdata[i]);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int r0;
    int beats;
    logic [AW-1:0] base;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0;
    for (int i = 0; i < 65536; i++) begin
      ref_mem[i] = '0;
      slv_mem[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_cyc", wb_cyc, 1'b0);
    check("rst_stb", wb_stb, 1'b0);
    check("rst_we", wb_we, 1'b0);
    check("rst_adr", wb_adr, 0);
    check("rst_dat_m", wb_dat_m, 0);
    check("rst_outputs", {rsp_valid, done, err, wr_ready}, 0);
    check("rst_rsp_data", rsp_data, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Spurious ACK while idle produces no response.
    r0 = rsp_cnt;
    @(posedge clk);
    #1;
    spur_req = 1;
    repeat (4) @(posedge clk);
    #1;
    check("spurious_ack_rsp", rsp_cnt - r0, 0);

    // Single write.
    wdata[0] = 16'd101;
    run_cmd(1'b1, 16'd1, 1, 0, 1'b0);
    check("single_stb_cycles", stb_hi, 1);

    // Write 211..220 to 11..20, then read back as a zero-wait burst.
    for (int i = 0; i < 10; i++) wdata[i] = DW'(211 + i);
    run_cmd(1'b1, 16'd11, 10, 0, 1'b0);
    run_cmd(1'b0, 16'd11, 10, 0, 1'b0);
    check("read_stb_cycles", stb_hi, 10);
    check("read_cyc_cycles", cyc_hi, 11);

    // Stalled write burst across the address wrap.
    waitcycles = 3;
    for (int i = 0; i < 4; i++) wdata[i] = DW'($urandom);
    run_cmd(1'b1, 16'hFFFE, 4, 0, 1'b0);
    check("stall_stb_cycles", stb_hi, 16);
    waitcycles = 0;
    run_cmd(1'b0, 16'hFFFE, 4, 0, 1'b0);

    // Write stream with gaps: STB follows wr_valid.
    for (int i = 0; i < 4; i++) wdata[i] = DW'($urandom);
    run_cmd(1'b1, 16'h0200, 4, 1, 1'b0);
    check("gap_stb_cycles", stb_hi, 4);
    check("gap_cyc_cycles", cyc_hi, 8);

    // Timeout: slave never acknowledges.
    no_ack = 1;
    run_cmd(1'b0, 16'h0040, 1, 0, 1'b1);
    check("timeout_latency", done_edge - issue_edge, TMO);
    check("timeout_cmd_ready_next", cmd_ready, 1'b1);
    check("timeout_cyc_next", wb_cyc, 1'b0);
    no_ack = 0;

    // Reset during beat 3 of an 8-beat read.
    for (int i = 0; i < 8; i++) begin
      exp_adr_q.push_back(16'h0100 + AW'(i));
      exp_q.push_back(ref_mem[16'h0100 + i]);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 16'h0100; cmd_len = 4'd7;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    done_cnt = 0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_cyc", wb_cyc, 1'b0);
    check("mid_rst_stb", wb_stb, 1'b0);
    check("mid_rst_rsp_valid", rsp_valid, 1'b0);
    repeat (3) @(posedge clk);
    exp_q.delete();
    exp_adr_q.delete();
    hold_data = '0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_no_done", done_cnt, 0);
    run_cmd(1'b0, 16'd11, 4, 0, 1'b0);

    // Randomised write/read-back pairs.
    for (int p = 0; p < 6; p++) begin
      beats = $urandom_range(1, 16);
      base = AW'($urandom);
      for (int i = 0; i < beats; i++) wdata[i] = DW'($urandom);
      waitcycles = $urandom_range(0, 2);
      run_cmd(1'b1, base, beats, 2, 1'b0);
      waitcycles = $urandom_range(0, 2);
      run_cmd(1'b0, base, beats, 0, 1'b0);
    end

    repeat (4) @(posedge clk);
    check("final_exp_q_empty", exp_q.size(), 0);
    check("final_exp_adr_empty", exp_adr_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
